// File: rtl/cluster_event_rx.sv
// cluster_event_rx: cluster-side receiver for the SoC-to-cluster token event bus.
// The SoC toggles one write-token bit per buffer slot; a slot is pending while its
// (synchronised) write token differs from the local read-pointer bit. Slots are
// popped strictly in ring order onto a valid/ready stream, and each pop toggles the
// slot's read-pointer bit so the writer can reuse it.
// Optional feature macro: CLUSTER_EVT_RX_SYNC_EN -- adds a 2-flop synchroniser on
// every write-token bit (asynchronous SoC clock). Without it the tokens are used
// directly (same-clock integration, zero latency).

// Per-slot cell: token synchroniser (optional) plus the read-pointer toggle bit.
module cluster_event_rx_slot (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wt_i,
  input  logic pop_i,
  output logic wt_sync_o,
  output logic rp_o
);

`ifdef CLUSTER_EVT_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchroniser; bit 1 is the metastability-safe token seen by the core.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], wt_i};
  end

  assign wt_sync_o = sync_q[1];
`else
  assign wt_sync_o = wt_i;
`endif

  logic rp_q, rp_d;

  // A pop of this slot flips its read pointer, handing the slot back to the writer.
  always_comb begin
    rp_d = rp_q ^ pop_i;
  end

  // Read-pointer bit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rp_q <= 1'b0;
    else       rp_q <= rp_d;
  end

  assign rp_o = rp_q;

endmodule

// Top: ring-ordered pop of pending slots, occupancy count and sticky order check.
module cluster_event_rx #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [BUFFER_WIDTH-1:0]              events_wt_i,
  input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0]   events_da_i,
  output logic [BUFFER_WIDTH-1:0]              events_rp_o,
  output logic                                 evt_valid_o,
  output logic [EVNT_WIDTH-1:0]                evt_data_o,
  input  logic                                 evt_ready_i,
  output logic [$clog2(BUFFER_WIDTH+1)-1:0]    fill_o,
  output logic                                 err_o
);

  localparam int IDX_W  = $clog2(BUFFER_WIDTH);
  localparam int FILL_W = $clog2(BUFFER_WIDTH+1);

  logic [BUFFER_WIDTH-1:0]                 wt_sync;
  logic [BUFFER_WIDTH-1:0]                 rp_vec;
  logic [BUFFER_WIDTH-1:0]                 pend;
  logic [BUFFER_WIDTH-1:0]                 pop_sel;
  logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0] slots;
  logic [IDX_W-1:0]                        rd_idx_q, rd_idx_d;
  logic                                    err_q, err_d;
  logic                                    pop;
  logic [FILL_W-1:0]                       fill;

  // Per-slot token/read-pointer cells.
  for (genvar g = 0; g < BUFFER_WIDTH; g++) begin : g_slot
    cluster_event_rx_slot u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wt_i      (events_wt_i[g]),
      .pop_i     (pop_sel[g]),
      .wt_sync_o (wt_sync[g]),
      .rp_o      (rp_vec[g])
    );
  end

  assign slots = events_da_i;
  assign pend  = wt_sync ^ rp_vec;

  // Head of the ring drives the stream; ready only matters while the head is pending.
  always_comb begin
    evt_valid_o = pend[rd_idx_q];
    evt_data_o  = slots[rd_idx_q];
    pop         = evt_valid_o & evt_ready_i;
    pop_sel     = pop ? (BUFFER_WIDTH'(1) << rd_idx_q) : '0;
  end

  // Advance the read index on a pop, wrapping at the last slot.
  always_comb begin
    rd_idx_d = rd_idx_q;
    if (pop) begin
      if (rd_idx_q == IDX_W'(BUFFER_WIDTH-1)) rd_idx_d = '0;
      else                                    rd_idx_d = rd_idx_q + 1'b1;
    end
  end

  // Slots fill in order, so anything pending while the head is empty means the
  // writer skipped a slot or a token was corrupted; latch it until reset.
  always_comb begin
    err_d = err_q | ((|pend) & ~pend[rd_idx_q]);
  end

  // Occupancy is the number of pending slots.
  always_comb begin
    fill = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) fill = fill + FILL_W'(pend[i]);
  end

  // Read index and sticky error register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  assign events_rp_o = rp_vec;
  assign fill_o      = fill;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cluster_event_rx.sv
// Bench for cluster_event_rx (BUFFER_WIDTH=8, EVNT_WIDTH=8). Latency follows the
// CLUSTER_EVT_RX_SYNC_EN build option.
module tb_cluster_event_rx;

  localparam int BW = 8;
  localparam int EW = 8;
`ifdef CLUSTER_EVT_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] wt;
  logic [BW*EW-1:0] da;
  logic [BW-1:0] rp;
  logic          valid;
  logic [EW-1:0] data;
  logic          ready;
  logic [3:0]    fill;
  logic          err;

  int ncmp  = 0;
  int nfail = 0;
  int npop  = 0;

  // Reference model: token pipeline delayed LAT edges, per-slot read pointers,
  // ring head index and sticky error.
  logic [BW-1:0] m_s1, m_s2, m_rp;
  int            m_idx;
  bit            m_err;

  cluster_event_rx #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW)) dut (
    .clk_i(clk), .rst_i(rst), .events_wt_i(wt), .events_da_i(da),
    .events_rp_o(rp), .evt_valid_o(valid), .evt_data_o(data),
    .evt_ready_i(ready), .fill_o(fill), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [BW-1:0] m_wt();
    return (LAT == 0) ? wt : m_s2;
  endfunction

  function automatic logic [BW-1:0] m_pend();
    return m_wt() ^ m_rp;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [BW-1:0] p;
    p = m_pend();
    chk("valid", 64'(valid), 64'(p[m_idx]));
    chk("data",  64'(data),  64'(da[m_idx*EW +: EW]));
    chk("rp",    64'(rp),    64'(m_rp));
    chk("fill",  64'(fill),  64'($countones(p)));
    chk("err",   64'(err),   64'(m_err));
  endtask

  task automatic model_edge();
    logic [BW-1:0] p;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_rp = '0; m_idx = 0; m_err = 1'b0;
    end else begin
      p = m_pend();
      if (p != 0 && !p[m_idx]) m_err = 1'b1;
      if (p[m_idx] && ready) begin
        m_rp[m_idx] = ~m_rp[m_idx];
        m_idx = (m_idx + 1) % BW;
      end
      m_s2 = m_s1;
      m_s1 = wt;
    end
  endtask

  // One clock: compare on the falling edge, then advance the model on the rising edge.
  task automatic cyc();
    @(negedge clk);
    check_all();
    if (valid && ready) npop++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wt = '0; ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; wt = '0; ready = 1'b0;
    da = {$urandom, $urandom};
    @(posedge clk); model_edge(); #1;

    // 1: reset with random tokens/data
    wt = 8'($urandom); da = {$urandom, $urandom};
    cyc(); cyc();
    chk("rst_rp",  64'(rp),  64'h0);
    chk("rst_err", 64'(err), 64'h0);
    do_reset();
    chk("rst_fill", 64'(fill), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);

    // 2: single event in slot 0
    da[7:0] = 8'hA5; ready = 1'b1; wt = 8'h01;
    for (int i = 0; i < LAT + 3; i++) cyc();
    chk("single_rp", 64'(rp), 64'h01);
    chk("single_fill", 64'(fill), 64'h0);

    // 3: full ring, drain in order, then wrap to slot 0
    do_reset();
    for (int i = 0; i < BW; i++) da[i*EW +: EW] = 8'(8'h10 + i);
    wt = 8'hFF;
    for (int i = 0; i < LAT + 2; i++) cyc();
    chk("full_fill", 64'(fill), 64'd8);
    ready = 1'b1; npop = 0;
    for (int i = 0; i < BW + 2; i++) cyc();
    chk("full_pops", 64'(npop), 64'd8);
    chk("full_rp", 64'(rp), 64'hFF);
    da[7:0] = 8'h5C; wt = 8'hFE; npop = 0;
    for (int i = 0; i < LAT + 3; i++) cyc();
    chk("wrap_pops", 64'(npop), 64'd1);
    chk("wrap_rp", 64'(rp), 64'hFE);

    // 4: backpressure with 3 pending
    do_reset();
    da = {$urandom, $urandom}; wt = 8'h07;
    for (int i = 0; i < LAT; i++) cyc();
    npop = 0;
    for (int i = 0; i < 5; i++) begin ready = (i % 2 == 0); cyc(); end
    ready = 1'b0; cyc(); cyc();
    chk("bp_pops", 64'(npop), 64'd3);
    chk("bp_rp", 64'(rp), 64'h07);

    // 5: out-of-order token sets sticky error
    do_reset();
    wt = 8'h04;
    for (int i = 0; i < 3; i++) cyc();
    chk("err_set", 64'(err), 64'h1);
    wt = 8'h00;
    for (int i = 0; i < 4; i++) cyc();
    chk("err_sticky", 64'(err), 64'h1);
    do_reset();
    chk("err_clr", 64'(err), 64'h0);

    // 6: reset mid-stream with tokens still driven
    wt = 8'h1F; ready = 1'b0;
    for (int i = 0; i < LAT + 1; i++) cyc();
    chk("mid_fill", 64'(fill), 64'd5);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rp", 64'(rp), 64'h0);
    for (int i = 0; i < LAT + 1; i++) cyc();
    chk("mid_refill", 64'(fill), 64'd5);
    ready = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("mid_rp_end", 64'(rp), 64'h1F);

    // Random writer honouring the slot-reuse protocol, random consumer ready.
    do_reset();
    w = 0;
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) != 0 && wt[w] == m_rp[w]) begin
        da[w*EW +: EW] = 8'($urandom);
        wt[w] = ~wt[w];
        w = (w + 1) % BW;
      end
      cyc();
    end
    chk("rand_err", 64'(err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
